// File: rtl/pipeline_control_unit_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_control_unit_pkg;

    localparam int STATE_W = 2;

    // FSM encodings; the numeric values are visible on state_o for debug.
    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_TRAP     = 2'd3
    } state_e;

    // One decoded set of per-stage controls.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic trap_ack;
        logic bus_err;
    } ctrl_t;

    // True when the control set freezes any pipeline register.
    function automatic logic any_stall(input ctrl_t c);
        return c.stall_if | c.stall_id | c.stall_ex | c.stall_mem;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count enabled cycles, holding at all-ones; clear has priority.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Central stall/flush sequencer for the 5-stage core. Merges load-use,
// branch redirect, mul/div occupancy, DMEM wait states and trap entry into
// one prioritised set of per-stage controls. Controls are decoded
// combinationally from state and inputs; state and counters are registered.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hazard_stall_i,
    input  logic             branch_taken_i,
    input  logic             md_start_i,
    input  logic             md_done_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             trap_req_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic             trap_ack_o,
    output logic             bus_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wide enough to hold DMEM_TIMEOUT itself; 0 collapses to a 1-bit stub.
    localparam int                WAIT_W     = $clog2(DMEM_TIMEOUT + 2);
    localparam logic              TIMEOUT_EN = (DMEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(DMEM_TIMEOUT - 1);

    state_e            state, state_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    ctrl_t             ctl;
    logic [CNT_W-1:0]  cnt_q;

    // Prioritised next-state and control decode.
    always_comb begin
        ctl     = '0;
        state_n = state;
        wait_n  = wait_cnt;
        case (state)
            ST_RUN: begin
                if (trap_req_i) begin
                    ctl.flush_id  = 1'b1;
                    ctl.flush_ex  = 1'b1;
                    ctl.flush_mem = 1'b1;
                    ctl.trap_ack  = 1'b1;
                    state_n       = ST_TRAP;
                end else if (dmem_req_i && !dmem_ack_i) begin
                    ctl.stall_if  = 1'b1;
                    ctl.stall_id  = 1'b1;
                    ctl.stall_ex  = 1'b1;
                    ctl.stall_mem = 1'b1;
                    state_n       = ST_MEM_WAIT;
                    wait_n        = WAIT_W'(1);
                end else if (md_start_i) begin
                    ctl.stall_if  = 1'b1;
                    ctl.stall_id  = 1'b1;
                    ctl.stall_ex  = 1'b1;
                    ctl.flush_mem = 1'b1;
                    state_n       = ST_MD_WAIT;
                end else if (branch_taken_i) begin
                    // Redirect squashes the dependent instruction, so the
                    // load-use stall is moot.
                    ctl.flush_id = 1'b1;
                    ctl.flush_ex = 1'b1;
                end else if (hazard_stall_i) begin
                    ctl.stall_if = 1'b1;
                    ctl.stall_id = 1'b1;
                    ctl.flush_ex = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                // Pending traps wait until the unit drains back to RUN.
                if (md_done_i) begin
                    state_n = ST_RUN;
                end else begin
                    ctl.stall_if  = 1'b1;
                    ctl.stall_id  = 1'b1;
                    ctl.stall_ex  = 1'b1;
                    ctl.flush_mem = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // A late ack on the timeout cycle still completes cleanly.
                if (dmem_ack_i) begin
                    state_n = ST_RUN;
                    wait_n  = '0;
                end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                    ctl.bus_err   = 1'b1;
                    ctl.flush_mem = 1'b1;
                    state_n       = ST_RUN;
                    wait_n        = '0;
                end else begin
                    ctl.stall_if  = 1'b1;
                    ctl.stall_id  = 1'b1;
                    ctl.stall_ex  = 1'b1;
                    ctl.stall_mem = 1'b1;
                    wait_n        = wait_cnt + 1'b1;
                end
            end
            ST_TRAP: begin
                // Drop the fetch issued before the redirect landed.
                ctl.flush_id = 1'b1;
                state_n      = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
                wait_n  = '0;
            end
        endcase
        if (reset_i)
            ctl = '0;
    end

    // State and DMEM wait counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk_i),
        .clr (reset_i),
        .en  (any_stall(ctl)),
        .q   (cnt_q)
    );

    // Output mapping; registered values are masked while reset is held.
    always_comb begin
        stall_if_o  = ctl.stall_if;
        stall_id_o  = ctl.stall_id;
        stall_ex_o  = ctl.stall_ex;
        stall_mem_o = ctl.stall_mem;
        flush_id_o  = ctl.flush_id;
        flush_ex_o  = ctl.flush_ex;
        flush_mem_o = ctl.flush_mem;
        trap_ack_o  = ctl.trap_ack;
        bus_err_o   = ctl.bus_err;
        state_o     = reset_i ? 2'd0 : 2'(state);
        stall_cnt_o = reset_i ? '0 : cnt_q;
    end

endmodule
